// File: rtl/qsys_key.sv
// -----------------------------------------------------------------------------
// qsys_key
//
// Avalon-MM slave input port for push-buttons/switches. The asynchronous
// in_port bus is brought into the clk domain through a two-flop synchronizer.
// Edges are detected on the synchronized value and latched into a sticky
// edge-capture register. A maskable level interrupt is raised while any
// captured edge is enabled.
//
// Register map (bits at and above WIDTH read 0, writes to them are ignored):
//   0 DATA     read-only, synchronized input value
//   1 reserved reads 0
//   2 IRQMASK  read/write, interrupt enable per bit
//   3 EDGECAP  read sticky edge bits, write 1 to clear per bit
//
// Parameters:
//   WIDTH      number of input bits (1-32)
//   EDGE_TYPE  0 = rising, 1 = falling, 2 = any edge
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-high reset
//   address     register select
//   chipselect  slave select, qualifies reads and writes
//   write_n     active-low write strobe (read = chipselect && write_n)
//   writedata   write data
//   readdata    registered read data, valid the cycle after the read
//   in_port     asynchronous external inputs
//   irq         active-high level interrupt
// -----------------------------------------------------------------------------
module qsys_key #(
    parameter int WIDTH     = 4,
    parameter int EDGE_TYPE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_s3;
    logic [1:0]       r_prime;
    logic [WIDTH-1:0] r_irqmask;
    logic [WIDTH-1:0] r_edgecap;
    logic [31:0]      r_readdata;

    logic             w_wr;
    logic             w_rd;
    logic             w_primed;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_edge_sel;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;
    logic [31:0]      w_rd_mux;
    logic             w_unused_wdata;

    assign w_wr = chipselect & ~write_n;
    assign w_rd = chipselect & write_n;

    // Only writedata[WIDTH-1:0] carries register content.
    assign w_unused_wdata = ^writedata;

    // Edge detection on the synchronized value; s3 is s2 one cycle ago.
    assign w_rise = r_s2 & ~r_s3;
    assign w_fall = ~r_s2 & r_s3;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        w_edge_sel = w_rise | w_fall;
        if (EDGE_TYPE == 0) begin
            w_edge_sel = w_rise;
        end else if (EDGE_TYPE == 1) begin
            w_edge_sel = w_fall;
        end
    end

    // The synchronizer resets to all-ones, so releasing reset with low inputs
    // looks like a falling edge; capture is held off until the chain has
    // flushed the reset value through s3.
    assign w_primed = (r_prime == 2'd3);
    assign w_edge   = w_primed ? w_edge_sel : '0;

    assign w_clr = (w_wr && (address == ADDR_EDGECAP)) ? writedata[WIDTH-1:0] : '0;

    always_comb begin
        w_rd_mux = '0;
        case (address)
            ADDR_DATA:    w_rd_mux[WIDTH-1:0] = r_s2;
            ADDR_RSVD:    w_rd_mux            = '0;
            ADDR_IRQMASK: w_rd_mux[WIDTH-1:0] = r_irqmask;
            ADDR_EDGECAP: w_rd_mux[WIDTH-1:0] = r_edgecap;
            default:      w_rd_mux            = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values; the synchronizer chain depends on it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1       <= '1;
            r_s2       <= '1;
            r_s3       <= '1;
            r_prime    <= 2'd0;
            r_irqmask  <= '0;
            r_edgecap  <= '0;
            r_readdata <= '0;
        end else begin
            r_s1 <= in_port;
            r_s2 <= r_s1;
            r_s3 <= r_s2;

            if (!w_primed) begin
                r_prime <= r_prime + 2'd1;
            end

            if (w_wr && (address == ADDR_IRQMASK)) begin
                r_irqmask <= writedata[WIDTH-1:0];
            end

            // A new edge overrides a simultaneous clear of the same bit.
            r_edgecap <= (r_edgecap & ~w_clr) | w_edge;

            // Read data is taken from the pre-edge register values and held
            // until the next read.
            if (w_rd) begin
                r_readdata <= w_rd_mux;
            end
        end
    end

    assign readdata = r_readdata;

    // Built from registers only, so bus inputs never reach irq combinationally.
    assign irq = |(r_edgecap & r_irqmask);

endmodule

// File: tb/tb_qsys_key.sv
module tb_qsys_key;

    localparam logic [1:0] K_IDLE = 2'd0;
    localparam logic [1:0] K_RD   = 2'd1;
    localparam logic [1:0] K_WR   = 2'd2;
    localparam int         NVEC   = 46;

    typedef struct {
        logic [1:0]  kind;
        logic [1:0]  addr;
        logic [31:0] wd;
        logic [3:0]  inp;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;

    logic [31:0] rd_fall, rd_rise, rd_any;
    logic        irq_fall, irq_rise, irq_any;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t vecs [NVEC];

    always #5 clk = ~clk;

    qsys_key #(.WIDTH(4), .EDGE_TYPE(1)) u_fall (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_fall),
        .in_port(in_port), .irq(irq_fall)
    );

    qsys_key #(.WIDTH(4), .EDGE_TYPE(0)) u_rise (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_rise),
        .in_port(in_port), .irq(irq_rise)
    );

    qsys_key #(.WIDTH(4), .EDGE_TYPE(2)) u_any (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_any),
        .in_port(in_port), .irq(irq_any)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drives one bus cycle at the falling edge, lets the rising edge sample
    // it, and returns at the next falling edge where outputs are stable.
    task automatic bus(input logic [1:0] kind, input logic [1:0] a, input logic [31:0] wd);
        chipselect = (kind != K_IDLE);
        write_n    = (kind != K_WR);
        address    = a;
        writedata  = wd;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bus(K_IDLE, 2'd0, 32'd0);
    endtask

    function automatic vec_t mk(input logic [1:0] k, input logic [1:0] a,
                                input logic [31:0] wd, input logic [3:0] inp,
                                input logic chk, input logic [31:0] rd,
                                input logic irq);
        vec_t v;
        v.kind = k; v.addr = a; v.wd = wd; v.inp = inp;
        v.chk_rd = chk; v.exp_rd = rd; v.exp_irq = irq;
        return v;
    endfunction

    initial begin
        // Falling-edge build: each record is one clock; expectations are the
        // state right after that clock edge.
        vecs[0]  = mk(K_IDLE, 0, 0, 4'h0, 0, 0, 0);
        vecs[1]  = mk(K_IDLE, 0, 0, 4'h0, 0, 0, 0);
        vecs[2]  = mk(K_IDLE, 0, 0, 4'h0, 0, 0, 0);
        vecs[3]  = mk(K_RD,   3, 0, 4'h0, 1, 32'h0, 0);  // no reset-induced edge
        vecs[4]  = mk(K_RD,   0, 0, 4'h0, 1, 32'h0, 0);
        vecs[5]  = mk(K_IDLE, 0, 0, 4'hF, 0, 0, 0);
        vecs[6]  = mk(K_IDLE, 0, 0, 4'hF, 0, 0, 0);
        vecs[7]  = mk(K_RD,   0, 0, 4'hF, 1, 32'hF, 0);  // DATA after 2 edges
        vecs[8]  = mk(K_RD,   1, 0, 4'hF, 1, 32'h0, 0);
        vecs[9]  = mk(K_RD,   2, 0, 4'hF, 1, 32'h0, 0);
        vecs[10] = mk(K_RD,   3, 0, 4'hF, 1, 32'h0, 0);  // rising ignored
        vecs[11] = mk(K_WR,   2, 32'h2, 4'hF, 0, 0, 0);
        vecs[12] = mk(K_IDLE, 0, 0, 4'hD, 0, 0, 0);
        vecs[13] = mk(K_IDLE, 0, 0, 4'hD, 0, 0, 0);      // not yet captured
        vecs[14] = mk(K_IDLE, 0, 0, 4'hD, 0, 0, 1);      // captured at k+2
        vecs[15] = mk(K_RD,   3, 0, 4'hD, 1, 32'h2, 1);
        vecs[16] = mk(K_RD,   0, 0, 4'hD, 1, 32'hD, 1);
        vecs[17] = mk(K_WR,   3, 32'h2, 4'hD, 1, 32'hD, 0); // W1C, readdata held
        vecs[18] = mk(K_WR,   2, 32'h0, 4'hD, 0, 0, 0);
        vecs[19] = mk(K_IDLE, 0, 0, 4'hC, 0, 0, 0);
        vecs[20] = mk(K_IDLE, 0, 0, 4'hC, 0, 0, 0);
        vecs[21] = mk(K_IDLE, 0, 0, 4'hC, 0, 0, 0);      // masked edge
        vecs[22] = mk(K_RD,   3, 0, 4'hC, 1, 32'h1, 0);
        vecs[23] = mk(K_WR,   2, 32'h1, 4'hC, 0, 0, 1);  // unmask -> irq
        vecs[24] = mk(K_WR,   2, 32'h2, 4'hC, 0, 0, 0);
        vecs[25] = mk(K_IDLE, 0, 0, 4'hE, 0, 0, 0);
        vecs[26] = mk(K_IDLE, 0, 0, 4'hE, 0, 0, 0);
        vecs[27] = mk(K_IDLE, 0, 0, 4'hE, 0, 0, 0);
        vecs[28] = mk(K_IDLE, 0, 0, 4'hC, 0, 0, 0);
        vecs[29] = mk(K_IDLE, 0, 0, 4'hC, 0, 0, 0);
        vecs[30] = mk(K_IDLE, 0, 0, 4'hC, 0, 0, 1);
        vecs[31] = mk(K_WR,   3, 32'h2, 4'hC, 0, 0, 0);  // W1C drops irq
        vecs[32] = mk(K_RD,   3, 0, 4'hC, 1, 32'h1, 0);
        vecs[33] = mk(K_IDLE, 0, 0, 4'hE, 0, 0, 0);
        vecs[34] = mk(K_IDLE, 0, 0, 4'hE, 0, 0, 0);
        vecs[35] = mk(K_IDLE, 0, 0, 4'hE, 0, 0, 0);
        vecs[36] = mk(K_IDLE, 0, 0, 4'hC, 0, 0, 0);
        vecs[37] = mk(K_IDLE, 0, 0, 4'hC, 0, 0, 0);
        vecs[38] = mk(K_WR,   3, 32'h2, 4'hC, 0, 0, 1);  // set beats W1C
        vecs[39] = mk(K_RD,   3, 0, 4'hC, 1, 32'h3, 1);
        vecs[40] = mk(K_WR,   3, 32'h1, 4'hC, 0, 0, 1);
        vecs[41] = mk(K_RD,   3, 0, 4'hC, 1, 32'h2, 1);
        vecs[42] = mk(K_WR,   0, 32'hFFFF_FFFF, 4'hC, 0, 0, 1); // DATA write ignored
        vecs[43] = mk(K_RD,   0, 0, 4'hC, 1, 32'hC, 1);
        vecs[44] = mk(K_WR,   2, 32'hFFFF_FFF0, 4'hC, 0, 0, 0); // upper bits ignored
        vecs[45] = mk(K_RD,   2, 0, 4'hC, 1, 32'h0, 0);

        reset = 1'b1; in_port = 4'h0;
        chipselect = 1'b0; write_n = 1'b1; address = 2'd0; writedata = 32'd0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        check("reset_rd", rd_fall, 32'h0);
        check("reset_irq", {31'd0, irq_fall}, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            in_port = vecs[i].inp;
            bus(vecs[i].kind, vecs[i].addr, vecs[i].wd);
            if (vecs[i].chk_rd) check($sformatf("vec%0d_rd", i), rd_fall, vecs[i].exp_rd);
            check($sformatf("vec%0d_irq", i), {31'd0, irq_fall}, {31'd0, vecs[i].exp_irq});
        end

        // Rising and any-edge builds: bit 3 low then high.
        bus(K_WR, 2'd3, 32'hF);
        in_port = 4'h4;
        idle(4);
        bus(K_RD, 2'd3, 32'd0);
        check("b3_fall_rise", rd_rise, 32'h0);
        check("b3_fall_any", rd_any, 32'h8);
        check("b3_fall_fall", rd_fall, 32'h8);
        bus(K_WR, 2'd3, 32'h8);
        bus(K_RD, 2'd3, 32'd0);
        check("b3_clr_rise", rd_rise, 32'h0);
        check("b3_clr_any", rd_any, 32'h0);
        in_port = 4'hC;
        idle(4);
        bus(K_RD, 2'd3, 32'd0);
        check("b3_rise_rise", rd_rise, 32'h8);
        check("b3_rise_any", rd_any, 32'h8);
        check("b3_rise_fall", rd_fall, 32'h0);
        bus(K_WR, 2'd2, 32'h8);
        check("b3_irq_rise", {31'd0, irq_rise}, 32'h1);
        check("b3_irq_any", {31'd0, irq_any}, 32'h1);
        check("b3_irq_fall", {31'd0, irq_fall}, 32'h0);

        // Load EDGECAP=F, IRQMASK=F on the falling build, then reset
        // asynchronously between clock edges.
        in_port = 4'hF;
        idle(4);
        in_port = 4'h0;
        idle(3);
        bus(K_WR, 2'd2, 32'hF);
        bus(K_RD, 2'd3, 32'd0);
        check("pre_rst_rd", rd_fall, 32'hF);
        check("pre_rst_irq", {31'd0, irq_fall}, 32'h1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_rd", rd_fall, 32'h0);
        check("async_rst_irq", {31'd0, irq_fall}, 32'h0);
        check("async_rst_irq_any", {31'd0, irq_any}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        idle(3);
        bus(K_RD, 2'd2, 32'd0);
        check("post_rst_mask", rd_fall, 32'h0);
        bus(K_RD, 2'd3, 32'd0);
        check("post_rst_edgecap", rd_fall, 32'h0);
        check("post_rst_edgecap_any", rd_any, 32'h0);
        check("post_rst_irq", {31'd0, irq_fall}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
